// File: rtl/ahblite_param_decoder.sv
// AHB-Lite address decoder with parameterised slave map, data-phase response mux
// and a built-in default slave that answers unmapped transfers with a two-cycle ERROR.
module ahblite_param_decoder #(
  parameter int                  NPORT   = 7,
  parameter logic [NPORT-1:0]    PORT_EN = '1,
  parameter logic [NPORT*16-1:0] BASE    = {16'h5002, 16'h5001, 16'h5000, 16'h4001,
                                            16'h4000, 16'h2000, 16'h0000},
  parameter logic [NPORT*16-1:0] LIMIT   = {16'h5002, 16'h5001, 16'h5000, 16'h4005,
                                            16'h4000, 16'h2000, 16'h0000}
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [NPORT-1:0]      HREADYOUT_S,
  input  logic [NPORT-1:0]      HRESP_S,
  input  logic [NPORT*32-1:0]   HRDATA_S,
  input  logic                  ERR_CLR,
  output logic [NPORT-1:0]      HSEL,
  output logic                  HREADY,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic                  DEC_ERR,
  output logic [31:0]           ERR_ADDR,
  output logic [7:0]            ERR_CNT
);

  localparam int IDX_W = (NPORT > 1) ? $clog2(NPORT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ERR1 = 2'd1,
    S_ERR2 = 2'd2
  } dflt_state_t;

  dflt_state_t      state;
  logic             dflt_ready;
  logic             dflt_resp;
  logic             dflt_p1;
  logic [IDX_W-1:0] dsel_p1;
  logic             hit_any;
  logic [IDX_W-1:0] hit_idx;
  logic             err_capture;
  logic             unused_htrans0;

  // Only HTRANS[1] distinguishes active transfers from IDLE/BUSY.
  assign unused_htrans0 = HTRANS[0];

  function automatic logic port_hit(input int k, input logic [15:0] a);
    port_hit = PORT_EN[k] && (a >= BASE[k*16 +: 16]) && (a <= LIMIT[k*16 +: 16]);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    sat_inc = (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  // Address phase: descending scan so the lowest-index hit is the one that sticks.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int k = NPORT - 1; k >= 0; k--) begin
      if (port_hit(k, HADDR[31:16])) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(k);
      end
    end
  end

  always_comb begin
    HSEL = '0;
    for (int k = 0; k < NPORT; k++) begin
      HSEL[k] = hit_any && (hit_idx == IDX_W'(k));
    end
  end

  // Data phase: response mux driven by the registered selection.
  always_comb begin
    HREADY = dflt_ready;
    HRESP  = dflt_resp;
    HRDATA = '0;
    if (!dflt_p1) begin
      HREADY = 1'b1;
      HRESP  = 1'b0;
      for (int k = 0; k < NPORT; k++) begin
        if (dsel_p1 == IDX_W'(k)) begin
          HREADY = HREADYOUT_S[k];
          HRESP  = HRESP_S[k];
          HRDATA = HRDATA_S[k*32 +: 32];
        end
      end
    end
  end

  assign err_capture = HREADY && !hit_any && HTRANS[1];

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state      <= S_IDLE;
      dflt_ready <= 1'b1;
      dflt_resp  <= 1'b0;
      dflt_p1    <= 1'b1;
      dsel_p1    <= '0;
      DEC_ERR    <= 1'b0;
      ERR_ADDR   <= '0;
      ERR_CNT    <= '0;
    end else begin
      if (HREADY) begin
        dflt_p1 <= !hit_any;
        dsel_p1 <= hit_idx;
      end

      case (state)
        S_IDLE: begin
          if (err_capture) begin
            state      <= S_ERR1;
            dflt_ready <= 1'b0;
            dflt_resp  <= 1'b1;
          end
        end
        S_ERR1: begin
          state      <= S_ERR2;
          dflt_ready <= 1'b1;
          dflt_resp  <= 1'b1;
        end
        S_ERR2: begin
          if (err_capture) begin
            state      <= S_ERR1;
            dflt_ready <= 1'b0;
            dflt_resp  <= 1'b1;
          end else begin
            state      <= S_IDLE;
            dflt_ready <= 1'b1;
            dflt_resp  <= 1'b0;
          end
        end
        default: begin
          state      <= S_IDLE;
          dflt_ready <= 1'b1;
          dflt_resp  <= 1'b0;
        end
      endcase

      DEC_ERR <= err_capture;
      // A capture on the same edge as a clear restarts the count at one.
      if (ERR_CLR) begin
        ERR_CNT  <= err_capture ? 8'd1 : 8'd0;
        ERR_ADDR <= err_capture ? HADDR : 32'h0;
      end else if (err_capture) begin
        ERR_CNT  <= sat_inc(ERR_CNT);
        ERR_ADDR <= HADDR;
      end
    end
  end

endmodule

// File: tb/tb_ahblite_param_decoder.sv
// Randomised scoreboard bench for ahblite_param_decoder: a transaction-level model
// predicts every cycle's outputs and a separate monitor compares them.
module tb_ahblite_param_decoder;

  localparam int NP = 7;
  // Port 0 disabled; port 5 widened so 0x5002 overlaps port 6 (port 5 must win).
  localparam logic [NP-1:0]    TB_EN    = 7'b1111110;
  localparam logic [NP*16-1:0] TB_BASE  = {16'h5002, 16'h5001, 16'h5000, 16'h4001,
                                           16'h4000, 16'h2000, 16'h0000};
  localparam logic [NP*16-1:0] TB_LIMIT = {16'h5002, 16'h5002, 16'h5000, 16'h4005,
                                           16'h4000, 16'h2000, 16'h0000};

  logic              HCLK;
  logic              HRESET;
  logic [31:0]       HADDR;
  logic [1:0]        HTRANS;
  logic [NP-1:0]     HREADYOUT_S;
  logic [NP-1:0]     HRESP_S;
  logic [NP*32-1:0]  HRDATA_S;
  logic              ERR_CLR;
  logic [NP-1:0]     HSEL;
  logic              HREADY;
  logic              HRESP;
  logic [31:0]       HRDATA;
  logic              DEC_ERR;
  logic [31:0]       ERR_ADDR;
  logic [7:0]        ERR_CNT;

  ahblite_param_decoder #(
    .NPORT  (NP),
    .PORT_EN(TB_EN),
    .BASE   (TB_BASE),
    .LIMIT  (TB_LIMIT)
  ) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .HADDR      (HADDR),
    .HTRANS     (HTRANS),
    .HREADYOUT_S(HREADYOUT_S),
    .HRESP_S    (HRESP_S),
    .HRDATA_S   (HRDATA_S),
    .ERR_CLR    (ERR_CLR),
    .HSEL       (HSEL),
    .HREADY     (HREADY),
    .HRESP      (HRESP),
    .HRDATA     (HRDATA),
    .DEC_ERR    (DEC_ERR),
    .ERR_ADDR   (ERR_ADDR),
    .ERR_CNT    (ERR_CNT)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [NP-1:0] hsel;
    logic          hready;
    logic          hresp;
    logic [31:0]   hrdata;
    logic          dec_err;
    logic [31:0]   err_addr;
    logic [7:0]    err_cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Reference model state: which slave owns the data phase (-1 = default slave),
  // the default slave's owed response beats {ready,resp}, and the error status.
  int         m_port;
  logic [1:0] m_beats[$];
  int         m_cnt;
  logic [31:0] m_addr;
  logic       m_dec;

  logic [15:0] hi_tab [16] = '{16'h0000, 16'h2000, 16'h2001, 16'h1FFF,
                               16'h4000, 16'h4001, 16'h4003, 16'h4005,
                               16'h4006, 16'h5000, 16'h5001, 16'h5002,
                               16'h5003, 16'h6000, 16'hFFFF, 16'h3FFF};

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int k = 0; k < NP; k++) begin
      if (TB_EN[k] && a[31:16] >= TB_BASE[k*16 +: 16] && a[31:16] <= TB_LIMIT[k*16 +: 16])
        return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_port = -1;
    m_beats.delete();
    m_cnt  = 0;
    m_addr = 32'h0;
    m_dec  = 1'b0;
  endtask

  // One bus cycle: drive inputs, predict this cycle's outputs, then advance the model
  // across the coming clock edge.
  task automatic do_cycle(input logic [31:0] addr, input logic [1:0] trans, input logic clr);
    exp_t e;
    int   k;
    logic err;
    @(negedge HCLK);
    HADDR   = addr;
    HTRANS  = trans;
    ERR_CLR = clr;
    for (int p = 0; p < NP; p++) begin
      HREADYOUT_S[p]       = ($urandom_range(3) != 0);
      HRESP_S[p]           = ($urandom_range(7) == 0);
      HRDATA_S[p*32 +: 32] = $urandom;
    end
    k = decode(addr);
    e.hsel = (k >= 0) ? (NP'(1) << k) : '0;
    if (m_port >= 0) begin
      e.hready = HREADYOUT_S[m_port];
      e.hresp  = HRESP_S[m_port];
      e.hrdata = HRDATA_S[m_port*32 +: 32];
    end else begin
      e.hrdata = 32'h0;
      if (m_beats.size() > 0) {e.hready, e.hresp} = m_beats[0];
      else                    {e.hready, e.hresp} = 2'b10;
    end
    e.dec_err  = m_dec;
    e.err_addr = m_addr;
    e.err_cnt  = m_cnt[7:0];
    exp_q.push_back(e);
    cyc++;

    if (m_port < 0 && m_beats.size() > 0) void'(m_beats.pop_front());
    err   = e.hready && (k < 0) && trans[1];
    m_dec = err;
    if (e.hready) m_port = k;
    if (err) begin
      m_beats.push_back(2'b01);
      m_beats.push_back(2'b11);
      m_addr = addr;
      m_cnt  = clr ? 1 : ((m_cnt >= 255) ? 255 : m_cnt + 1);
    end else if (clr) begin
      m_addr = 32'h0;
      m_cnt  = 0;
    end
  endtask

  // Monitor: compares whatever the model has predicted for the current cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge HCLK);
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("hsel",     32'(HSEL),     32'(e.hsel));
        check("hready",   32'(HREADY),   32'(e.hready));
        check("hresp",    32'(HRESP),    32'(e.hresp));
        check("hrdata",   HRDATA,        e.hrdata);
        check("dec_err",  32'(DEC_ERR),  32'(e.dec_err));
        check("err_addr", ERR_ADDR,      e.err_addr);
        check("err_cnt",  32'(ERR_CNT),  32'(e.err_cnt));
      end
    end
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [31:0] a;
    int n;
    HRESET      = 1'b1;
    HADDR       = 32'h2000_0000;
    HTRANS      = 2'b00;
    HREADYOUT_S = '1;
    HRESP_S     = '0;
    HRDATA_S    = '1;
    ERR_CLR     = 1'b0;
    model_reset();

    @(posedge HCLK);
    #1;
    check("rst_hready",   32'(HREADY),  32'd1);
    check("rst_hresp",    32'(HRESP),   32'd0);
    check("rst_hrdata",   HRDATA,       32'd0);
    check("rst_dec_err",  32'(DEC_ERR), 32'd0);
    check("rst_err_addr", ERR_ADDR,     32'd0);
    check("rst_err_cnt",  32'(ERR_CNT), 32'd0);
    check("rst_hsel",     32'(HSEL),    32'h02);
    #1 HRESET = 1'b0;

    // Directed address map and error-path cases.
    do_cycle(32'h2000_0010, 2'b10, 1'b0);
    do_cycle(32'h2000_0014, 2'b00, 1'b0);
    do_cycle(32'h4003_0000, 2'b10, 1'b0);
    do_cycle(32'h4006_0000, 2'b00, 1'b0);
    do_cycle(32'h5002_0000, 2'b10, 1'b0);
    do_cycle(32'h6000_0000, 2'b10, 1'b0);
    repeat (4) do_cycle(32'h2000_0000, 2'b00, 1'b0);
    repeat (3) do_cycle(32'h6000_0000, 2'b00, 1'b0);
    do_cycle(32'h6000_0000, 2'b01, 1'b0);
    do_cycle(32'h0000_0000, 2'b10, 1'b0);
    repeat (4) do_cycle(32'h0000_0000, 2'b00, 1'b0);

    // Randomised traffic, including address changes while stalled.
    for (int i = 0; i < 1500; i++) begin
      a = {hi_tab[$urandom_range(15)], 16'($urandom)};
      if ($urandom_range(7) == 0) a = $urandom;
      do_cycle(a, 2'($urandom_range(3)), ($urandom_range(15) == 0));
    end

    // Asynchronous reset in the middle of an error response.
    n = 0;
    do begin
      do_cycle(32'h6000_0000, 2'b10, 1'b0);
      n++;
    end while (!m_dec && n < 20);
    if (!m_dec) begin
      checks++;
      failures++;
      $display("FAIL err_setup cyc=%0d got=no_capture exp=capture", cyc);
    end
    do_cycle(32'h6000_0000, 2'b10, 1'b0);
    #3;
    HADDR  = 32'h4003_0000;
    HRESET = 1'b1;
    #1;
    check("arst_hready",  32'(HREADY),  32'd1);
    check("arst_hresp",   32'(HRESP),   32'd0);
    check("arst_err_cnt", 32'(ERR_CNT), 32'd0);
    check("arst_dec_err", 32'(DEC_ERR), 32'd0);
    check("arst_hsel",    32'(HSEL),    32'h08);
    model_reset();
    @(posedge HCLK);
    #1 HRESET = 1'b0;

    // Back-to-back unmapped transfers until the counter saturates.
    for (int i = 0; i < 600; i++) do_cycle(32'h6000_0000, 2'b11, 1'b0);
    #3;
    check("err_cnt_sat", 32'(ERR_CNT), 32'hFF);
    repeat (4) do_cycle(32'h6000_0000, 2'b10, 1'b1);
    repeat (4) do_cycle(32'h4000_0000, 2'b00, 1'b0);

    repeat (3) @(negedge HCLK);
    #3;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain cyc=%0d got=%0d exp=0", cyc, exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
